entrada_operandos: RTL and testbench

Keypad operand sequencer for the BCD calculator. It sits directly upstream of the BCD digit adder. It accepts key codes one at a time and captures a first digit, the '+' operator, a second digit and '='. It then presents the two operands on `A`/`B` and strobes `agora` for one cycle so the adder computes the sum.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/filtro_tecla.sv | 40 ++++
 rtl/entrada_operandos.sv | 102 ++++++++++
 tb/tb_entrada_operandos.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator: key codes, operand sequencer
// state encoding and the BCD digit type.
package calc_pkg;

    localparam logic [3:0] TECLA_MAIS  = 4'hA;
    localparam logic [3:0] TECLA_IGUAL = 4'hB;
    localparam logic [3:0] TECLA_LIMPA = 4'hC;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        ESPERA_A     = 3'd0,
        ESPERA_OP    = 3'd1,
        ESPERA_B     = 3'd2,
        ESPERA_IGUAL = 3'd3,
        DISPARO      = 3'd4
    } estado_t;

    function automatic logic eh_digito(input logic [3:0] codigo);
        return codigo <= 4'd9;
    endfunction

    function automatic logic eh_invalida(input logic [3:0] codigo);
        return codigo >= 4'hD;
    endfunction

endpackage

// File: rtl/filtro_tecla.sv
// Key-present debounce: two-flop synchronizer followed by a consecutive-high
// counter; emits one registered accept strobe per press.
module filtro_tecla #(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tecla_valida,
    output logic aceita
);

    localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS);

    logic       sinc1_reg;
    logic       sinc2_reg;
    logic [7:0] cont_reg;
    logic       aceita_reg;

    // Counter saturates at LIMITE so a held key is accepted only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc1_reg  <= 1'b0;
            sinc2_reg  <= 1'b0;
            cont_reg   <= '0;
            aceita_reg <= 1'b0;
        end else begin
            sinc1_reg  <= tecla_valida;
            sinc2_reg  <= sinc1_reg;
            if (!sinc2_reg) begin
                cont_reg <= '0;
            end else if (cont_reg != LIMITE) begin
                cont_reg <= cont_reg + 8'd1;
            end
            aceita_reg <= sinc2_reg && (cont_reg == LIMITE - 8'd1);
        end
    end

    assign aceita = aceita_reg;

endmodule

// File: rtl/entrada_operandos.sv
// Keypad operand sequencer feeding the BCD adder: digit '+' digit '=' -> agora.
// Optional input debounce enabled by defining ENTRADA_DEBOUNCE_EN.
import calc_pkg::*;

module entrada_operandos #(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_valida,
    input  logic [3:0] tecla,
    output bcd_t       A,
    output bcd_t       B,
    output logic       agora,
    output logic       erro,
    output logic [2:0] estado
);

    estado_t estado_reg, estado_next;
    bcd_t    a_reg, a_next;
    bcd_t    b_reg, b_next;
    logic    agora_reg, agora_next;
    logic    erro_reg, erro_next;
    logic    aceita;

`ifdef ENTRADA_DEBOUNCE_EN
    filtro_tecla #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro (
        .clk          (clk),
        .rst          (rst),
        .tecla_valida (tecla_valida),
        .aceita       (aceita)
    );
`else
    logic unused_debounce;
    assign unused_debounce = ^8'(DEBOUNCE_CICLOS);
    assign aceita          = tecla_valida;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg <= ESPERA_A;
            a_reg      <= '0;
            b_reg      <= '0;
            agora_reg  <= 1'b0;
            erro_reg   <= 1'b0;
        end else begin
            estado_reg <= estado_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            agora_reg  <= agora_next;
            erro_reg   <= erro_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        if (estado_reg == DISPARO) begin
            estado_next = ESPERA_A;
        end else if (aceita && tecla == TECLA_LIMPA) begin
            estado_next = ESPERA_A;
        end else if (aceita) begin
            case (estado_reg)
                ESPERA_A:     if (eh_digito(tecla))    estado_next = ESPERA_OP;
                ESPERA_OP:    if (tecla == TECLA_MAIS)  estado_next = ESPERA_B;
                ESPERA_B:     if (eh_digito(tecla))    estado_next = ESPERA_IGUAL;
                ESPERA_IGUAL: if (tecla == TECLA_IGUAL) estado_next = DISPARO;
                default:      estado_next = ESPERA_A;
            endcase
        end
    end

    // Strobe is registered: high in the cycle the state register holds DISPARO.
    always_comb begin
        a_next     = a_reg;
        b_next     = b_reg;
        erro_next  = 1'b0;
        agora_next = (estado_next == DISPARO);
        if (aceita) begin
            if (estado_reg == DISPARO || eh_invalida(tecla)) begin
                erro_next = 1'b1;
            end else if (tecla == TECLA_LIMPA) begin
                a_next = '0;
                b_next = '0;
            end else if (eh_digito(tecla)) begin
                if (estado_reg == ESPERA_A || estado_reg == ESPERA_OP) begin
                    a_next = tecla;
                end else begin
                    b_next = tecla;
                end
            end
        end
    end

    assign A      = a_reg;
    assign B      = b_reg;
    assign agora  = agora_reg;
    assign erro   = erro_reg;
    assign estado = estado_reg;

endmodule

// File: tb/tb_entrada_operandos.sv
// Directed bench for entrada_operandos; the debounce scenario runs when
// ENTRADA_DEBOUNCE_EN is defined, the sequencing scenarios otherwise.
module tb_entrada_operandos;

    logic       clk;
    logic       rst;
    logic       tecla_valida;
    logic [3:0] tecla;
    logic [3:0] A;
    logic [3:0] B;
    logic       agora;
    logic       erro;
    logic [2:0] estado;

    int n_verif;
    int n_falhas;

    entrada_operandos #(
        .DEBOUNCE_CICLOS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_valida (tecla_valida),
        .tecla        (tecla),
        .A            (A),
        .B            (B),
        .agora        (agora),
        .erro         (erro),
        .estado       (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input int got, input int exp);
        n_verif++;
        if (got !== exp) begin
            n_falhas++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Drive one cycle of input from a negedge; returns at the next negedge,
    // after the rising edge that consumed it.
    task automatic ciclo(input logic v, input logic [3:0] k);
        tecla_valida = v;
        tecla        = k;
        @(negedge clk);
    endtask

    task automatic saidas(input string tag, input int ea, input int eb,
                          input int eag, input int eer, input int ees);
        verifica({tag, ".A"},      int'(A),      ea);
        verifica({tag, ".B"},      int'(B),      eb);
        verifica({tag, ".agora"},  int'(agora),  eag);
        verifica({tag, ".erro"},   int'(erro),   eer);
        verifica({tag, ".estado"}, int'(estado), ees);
    endtask

    initial begin
        n_verif      = 0;
        n_falhas     = 0;
        rst          = 1'b1;
        tecla_valida = 1'b0;
        tecla        = 4'h0;
        #3;
        saidas("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

`ifdef ENTRADA_DEBOUNCE_EN
        begin
            int n_erro;
            int primeiro;
            // high 3 / low 1 / high 6 of an invalid key: one erro pulse expected
            n_erro   = 0;
            primeiro = -1;
            for (int i = 0; i < 24; i++) begin
                ciclo((i < 3) || (i >= 4 && i < 10), 4'hE);
                if (erro) begin
                    n_erro++;
                    if (primeiro < 0) primeiro = i;
                end
            end
            verifica("deb.n_aceites", n_erro, 1);
            verifica("deb.ciclo_aceite", primeiro, 10);
            verifica("deb.estado", int'(estado), 0);
            for (int i = 0; i < 12; i++) ciclo(i < 8, 4'd5);
            verifica("deb.A", int'(A), 5);
            verifica("deb.estado_op", int'(estado), 1);
        end
`else
        // 3 + 4 =
        ciclo(1'b1, 4'd3);  saidas("t1.d3", 3, 0, 0, 0, 1);
        ciclo(1'b1, 4'hA);  saidas("t1.mais", 3, 0, 0, 0, 2);
        ciclo(1'b1, 4'd4);  saidas("t1.d4", 3, 4, 0, 0, 3);
        ciclo(1'b1, 4'hB);  saidas("t1.disparo", 3, 4, 1, 0, 4);
        ciclo(1'b0, 4'hB);  saidas("t1.volta", 3, 4, 0, 0, 0);
        ciclo(1'b0, 4'h0);  saidas("t1.retem", 3, 4, 0, 0, 0);

        // 2 5 = + 1 7 =  (early '=' ignored silently)
        ciclo(1'b1, 4'd2);  saidas("t2.d2", 2, 4, 0, 0, 1);
        ciclo(1'b1, 4'd5);  saidas("t2.d5", 5, 4, 0, 0, 1);
        ciclo(1'b1, 4'hB);  saidas("t2.igual_cedo", 5, 4, 0, 0, 1);
        ciclo(1'b1, 4'hA);  saidas("t2.mais", 5, 4, 0, 0, 2);
        ciclo(1'b1, 4'd1);  saidas("t2.d1", 5, 1, 0, 0, 3);
        ciclo(1'b1, 4'd7);  saidas("t2.d7", 5, 7, 0, 0, 3);
        ciclo(1'b1, 4'hB);  saidas("t2.disparo", 5, 7, 1, 0, 4);
        ciclo(1'b0, 4'h0);  saidas("t2.volta", 5, 7, 0, 0, 0);

        // 6 + 8 C, then 1 + 1 =
        ciclo(1'b1, 4'd6);
        ciclo(1'b1, 4'hA);
        ciclo(1'b1, 4'd8);  saidas("t3.d8", 6, 8, 0, 0, 3);
        ciclo(1'b1, 4'hC);  saidas("t3.limpa", 0, 0, 0, 0, 0);
        ciclo(1'b0, 4'h0);  saidas("t3.pos", 0, 0, 0, 0, 0);
        ciclo(1'b1, 4'd1);
        ciclo(1'b1, 4'hA);
        ciclo(1'b1, 4'd1);
        ciclo(1'b1, 4'hB);  saidas("t3.disparo", 1, 1, 1, 0, 4);
        ciclo(1'b0, 4'h0);

        // invalid key in ESPERA_B, then a key during DISPARO
        ciclo(1'b1, 4'd3);
        ciclo(1'b1, 4'hA);  saidas("t4.esp_b", 3, 1, 0, 0, 2);
        ciclo(1'b1, 4'hE);  saidas("t4.invalida", 3, 1, 0, 1, 2);
        ciclo(1'b0, 4'hE);  saidas("t4.erro_fim", 3, 1, 0, 0, 2);
        ciclo(1'b1, 4'd5);
        ciclo(1'b1, 4'hB);  saidas("t4.disparo", 3, 5, 1, 0, 4);
        ciclo(1'b1, 4'd7);  saidas("t4.descartada", 3, 5, 0, 1, 0);
        ciclo(1'b0, 4'h0);  saidas("t4.pos", 3, 5, 0, 0, 0);

        // invalid key with tecla_valida low is never sampled
        ciclo(1'b0, 4'hF);  saidas("t4.nao_valida", 3, 5, 0, 0, 0);

        // asynchronous reset in ESPERA_IGUAL with 9 + 9
        ciclo(1'b1, 4'd9);
        ciclo(1'b1, 4'hA);
        ciclo(1'b1, 4'd9);  saidas("t5.pre", 9, 9, 0, 0, 3);
        tecla_valida = 1'b1;
        tecla        = 4'hB;
        #2 rst = 1'b1;
        #1;
        saidas("t5.rst_async", 0, 0, 0, 0, 0);
        @(negedge clk);
        saidas("t5.rst_mantido", 0, 0, 0, 0, 0);
        rst = 1'b0;
        ciclo(1'b1, 4'hB);  saidas("t5.igual_ignorado", 0, 0, 0, 0, 0);
        ciclo(1'b0, 4'h0);  saidas("t5.fim", 0, 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule
